// File: rtl/as_gpio_tx_pkg.sv
// Shared types and default sizes for the GPIO transmit path.
// The request struct and FSM state type are visible to any block driving or observing the GPIO pins.
package as_gpio_tx_pkg;

    localparam int nr_gpios        = 8;
    localparam int gpio_addr_width = 8;
    localparam int gpio_fifo_depth = 4;

    typedef struct packed {
        logic [gpio_addr_width-1:0] addr;
        logic [nr_gpios-1:0]        data;
    } gpio_req_t;

    typedef enum logic [1:0] {
        GT_IDLE,
        GT_SEND,
        GT_GAP
    } gpio_tx_state_t;

    // Width of a down-counter that must hold the value 'gap' (at least one bit).
    function automatic int gap_cnt_w(input int gap);
        return (gap < 1) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/as_gpio_tx_fifo.sv
// Generic synchronous FIFO: power-of-two depth, registered count, full/empty from count.
// A push while full and a pop while empty are ignored; data storage is not reset.
module as_gpio_tx_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    // Full is judged on the registered count, so a pop in the same cycle does not free a slot.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/as_gpio_tx.sv
// GPIO transmit side: queues CPU stores to the GPIO window and replays each one
// as a single-cycle cs_o strobe with gpioAddr_o/gpio_o held until the next transfer.
module as_gpio_tx
    import as_gpio_tx_pkg::*;
#(
    parameter int DATA_W     = nr_gpios,
    parameter int ADDR_W     = gpio_addr_width,
    parameter int DEPTH      = gpio_fifo_depth,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic              ovf_o,
    input  logic              clr_ovf_i,
    output logic              cs_o,
    output logic [ADDR_W-1:0] gpioAddr_o,
    output logic [DATA_W-1:0] gpio_o,
    output logic              busy_o,
    output gpio_tx_state_t    dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = gap_cnt_w(GAP_CYCLES);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t           push_req;
    req_t           head;
    logic           full;
    logic           empty;
    logic [CW-1:0]  count;
    logic           pop;
    gpio_tx_state_t state;
    gpio_tx_state_t state_nxt;
    logic [GW-1:0]  gap_cnt;

    assign push_req = '{addr: addr_i, data: wdata_i};

    as_gpio_tx_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_i),
        .push  (we_i),
        .pop   (pop),
        .wdata (push_req),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= GT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The last gap cycle pops directly when work is waiting, so strobes sit exactly
    // GAP_CYCLES idle cycles apart instead of spending an extra cycle in IDLE.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            GT_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = GT_SEND;
                end
            end
            GT_SEND: begin
                if (GAP_CYCLES > 0) begin
                    state_nxt = GT_GAP;
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    state_nxt = GT_IDLE;
                end
            end
            GT_GAP: begin
                if (gap_cnt == GW'(1)) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = GT_SEND;
                    end else begin
                        state_nxt = GT_IDLE;
                    end
                end
            end
            default: state_nxt = GT_IDLE;
        endcase
    end

    always_comb begin
        cs_o      = (state == GT_SEND);
        busy_o    = (count != '0) || (state != GT_IDLE);
        dbg_state = state;
    end

    assign stall_o = full;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gap_cnt <= '0;
        end else if (state == GT_SEND) begin
            gap_cnt <= GW'(GAP_CYCLES);
        end else if (state == GT_GAP) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gpioAddr_o <= '0;
            gpio_o     <= '0;
        end else if (pop) begin
            gpioAddr_o <= head.addr;
            gpio_o     <= head.data;
        end
    end

    // A new overflow wins over a clear arriving in the same cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_o <= 1'b0;
        end else if (we_i && full) begin
            ovf_o <= 1'b1;
        end else if (clr_ovf_i) begin
            ovf_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_as_gpio_tx.sv
// Bench for as_gpio_tx: three instances (gap 0, 2, 8) share one stimulus stream,
// each with its own expected queue of accepted stores.
module tb_as_gpio_tx;
    import as_gpio_tx_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int GAP0 = 0;
    localparam int GAP1 = 2;
    localparam int GAP2 = 8;

    logic          clk;
    logic          rst_i;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          clr;

    logic           stall [3];
    logic           ovf   [3];
    logic           cs    [3];
    logic [AW-1:0]  ga    [3];
    logic [DW-1:0]  gd    [3];
    logic           busy  [3];
    gpio_tx_state_t dbg   [3];

    int gap_of [3];
    logic [AW+DW-1:0] exp_q [3][$];
    int strobe_at [3][$];
    int cyc;
    int n_vec;
    int n_err;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          clr;
        logic [3:0]    flags;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t tbl [11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    as_gpio_tx #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .GAP_CYCLES(GAP0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .stall_o(stall[0]), .ovf_o(ovf[0]), .clr_ovf_i(clr), .cs_o(cs[0]),
        .gpioAddr_o(ga[0]), .gpio_o(gd[0]), .busy_o(busy[0]), .dbg_state(dbg[0])
    );
    as_gpio_tx #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .GAP_CYCLES(GAP1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .stall_o(stall[1]), .ovf_o(ovf[1]), .clr_ovf_i(clr), .cs_o(cs[1]),
        .gpioAddr_o(ga[1]), .gpio_o(gd[1]), .busy_o(busy[1]), .dbg_state(dbg[1])
    );
    as_gpio_tx #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .GAP_CYCLES(GAP2)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .stall_o(stall[2]), .ovf_o(ovf[2]), .clr_ovf_i(clr), .cs_o(cs[2]),
        .gpioAddr_o(ga[2]), .gpio_o(gd[2]), .busy_o(busy[2]), .dbg_state(dbg[2])
    );

    function automatic logic [19:0] outs(input int k);
        return {stall[k], ovf[k], cs[k], busy[k], ga[k], gd[k]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // One clock: record stores each instance will accept, advance, then score strobes.
    task automatic tick();
        logic [AW+DW-1:0] e;
        for (int k = 0; k < 3; k++) begin
            if (rst_i && we && !stall[k]) exp_q[k].push_back({addr, wdata});
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (cs[k]) begin
                if (strobe_at[k].size() > 0) begin
                    n_vec++;
                    if (cyc - strobe_at[k][$] < gap_of[k] + 1) begin
                        n_err++;
                        $display("FAIL spacing dut%0d: got %0d cycles expected >= %0d",
                                 k, cyc - strobe_at[k][$], gap_of[k] + 1);
                    end
                end
                strobe_at[k].push_back(cyc);
                n_vec++;
                if (exp_q[k].size() == 0) begin
                    n_err++;
                    $display("FAIL strobe dut%0d: got addr=%h data=%h expected no strobe",
                             k, ga[k], gd[k]);
                end else begin
                    e = exp_q[k].pop_front();
                    if ({ga[k], gd[k]} !== e) begin
                        n_err++;
                        $display("FAIL strobe dut%0d: got %h expected %h", k, {ga[k], gd[k]}, e);
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic c);
        we = w; addr = a; wdata = d; clr = c;
    endtask

    task automatic drain();
        int n;
        drive(1'b0, '0, '0, 1'b0);
        n = 0;
        while ((busy[0] || busy[1] || busy[2]) && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(n < 200), 32'(1));
    endtask

    initial begin
        gap_of[0] = GAP0; gap_of[1] = GAP1; gap_of[2] = GAP2;
        cyc = 0; n_vec = 0; n_err = 0;
        rst_i = 1'b0;
        drive(1'b0, '0, '0, 1'b0);

        tbl[0]  = '{1'b1, 8'h04, 8'h01, 1'b0, 4'b0001, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 8'h00, 8'h00, 1'b0, 4'b0011, 8'h04, 8'h01};
        tbl[2]  = '{1'b0, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h04, 8'h01};
        tbl[3]  = '{1'b1, 8'h04, 8'h01, 1'b0, 4'b0001, 8'h04, 8'h01};
        tbl[4]  = '{1'b1, 8'h04, 8'h05, 1'b0, 4'b0011, 8'h04, 8'h01};
        tbl[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, 4'b0011, 8'h04, 8'h05};
        tbl[6]  = '{1'b0, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h04, 8'h05};
        tbl[7]  = '{1'b1, 8'h07, 8'h3c, 1'b0, 4'b0001, 8'h04, 8'h05};
        tbl[8]  = '{1'b1, 8'h09, 8'hff, 1'b0, 4'b0011, 8'h07, 8'h3c};
        tbl[9]  = '{1'b0, 8'h00, 8'h00, 1'b1, 4'b0011, 8'h09, 8'hff};
        tbl[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h09, 8'hff};

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_outs dut%0d", k), 32'(outs(k)), 32'(0));
            check($sformatf("reset_state dut%0d", k), 32'(dbg[k]), 32'(GT_IDLE));
        end
        @(posedge clk);
        #1;
        rst_i = 1'b1;

        // Single store and back-to-back stores on the gap-0 instance
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].clr);
            tick();
            check($sformatf("vec%0d dut0", i), 32'(outs(0)),
                  32'({tbl[i].flags, tbl[i].ea, tbl[i].ed}));
        end
        drain();

        // Gap of 2: three stores strobe exactly three cycles apart
        strobe_at[1].delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h11 + i), 8'(8'ha1 + i), 1'b0);
            tick();
        end
        drain();
        check("gap2_count", 32'(strobe_at[1].size()), 32'(3));
        if (strobe_at[1].size() == 3) begin
            check("gap2_space1", 32'(strobe_at[1][1] - strobe_at[1][0]), 32'(3));
            check("gap2_space2", 32'(strobe_at[1][2] - strobe_at[1][1]), 32'(3));
        end

        // Overflow on the gap-8 instance: pop blocked by the long gap
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(8'h20 + i), 8'(8'h21 + i), 1'b0);
            tick();
            check($sformatf("ovf_seq%0d dut2", i), 32'({stall[2], ovf[2]}),
                  (i == 4) ? 32'b10 : (i == 5) ? 32'b11 : 32'b00);
        end
        drive(1'b1, 8'h26, 8'h27, 1'b1);
        tick();
        check("ovf_beats_clr dut2", 32'({stall[2], ovf[2]}), 32'b11);
        drive(1'b0, '0, '0, 1'b1);
        tick();
        check("ovf_clear dut2", 32'({stall[2], ovf[2]}), 32'b10);
        drain();

        // Reset while dut2 strobes with three entries still queued
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h31 + i), 8'(8'h41 + i), 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        tick();
        begin
            int n;
            n = 0;
            while (!cs[2] && n < 40) begin
                tick();
                n++;
            end
            check("reset_wait_strobe", 32'(n < 40), 32'(1));
        end
        check("pre_reset_busy dut2", 32'({cs[2], busy[2]}), 32'b11);
        #1;
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q[k].delete();
            strobe_at[k].delete();
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midreset_outs dut%0d", k), 32'(outs(k)), 32'(0));
        end
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        repeat (30) tick();
        check("post_reset_strobes dut2", 32'(strobe_at[2].size()), 32'(0));

        // Random traffic against the per-instance expected queues
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
            tick();
        end
        drain();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("leftover dut%0d", k), 32'(exp_q[k].size()), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
